// File: rtl/spgd_metric_pair_if.sv
// Handshake and data bundle between the ADC gain path, the metric pairing block
// and the gradient/update stage of the SPGD loop.
interface spgd_metric_pair_if #(
  parameter int FLOAT_WIDTH = 64,
  parameter int CNT_WIDTH   = 16
);
  logic [FLOAT_WIDTH-1:0] DATA_IN;
  logic                   REG_WRITE;
  logic                   REG_RST;
  logic                   DELTA_READY;
  logic                   CLR_OVERRUN;
  logic                   PERT_SEL;
  logic [FLOAT_WIDTH-1:0] J_PLUS;
  logic [FLOAT_WIDTH-1:0] J_MINUS;
  logic [FLOAT_WIDTH-1:0] DELTA_J;
  logic                   DELTA_VALID;
  logic                   OVERRUN;
  logic [CNT_WIDTH-1:0]   PAIR_COUNT;

  modport master (
    output DATA_IN, REG_WRITE, REG_RST, DELTA_READY, CLR_OVERRUN,
    input  PERT_SEL, J_PLUS, J_MINUS, DELTA_J, DELTA_VALID, OVERRUN, PAIR_COUNT
  );

  modport slave (
    input  DATA_IN, REG_WRITE, REG_RST, DELTA_READY, CLR_OVERRUN,
    output PERT_SEL, J_PLUS, J_MINUS, DELTA_J, DELTA_VALID, OVERRUN, PAIR_COUNT
  );
endinterface

// File: rtl/spgd_metric_pair.sv
// Pairs J+/J- metric samples, presents the saturated difference dJ = J+ - J-
// over a valid/ready handshake and drives the perturbation polarity select.
module spgd_metric_pair #(
  parameter int FLOAT_WIDTH = 64,
  parameter int INT_WIDTH   = 16,
  parameter int CNT_WIDTH   = 16
) (
  input logic               ADC_CLK,
  input logic               RST_N,
  spgd_metric_pair_if.slave bus
);

  localparam logic [1:0] WAIT_PLUS  = 2'd0;
  localparam logic [1:0] WAIT_MINUS = 2'd1;
  localparam logic [1:0] PRESENT    = 2'd2;

  if (INT_WIDTH < 1 || INT_WIDTH > FLOAT_WIDTH) begin : g_bad_format
    $error("INT_WIDTH must lie within 1..FLOAT_WIDTH");
  end

  logic [1:0]             state;
  logic                   pert_sel;
  logic                   delta_valid;
  logic                   overrun;
  logic [FLOAT_WIDTH-1:0] j_plus;
  logic [FLOAT_WIDTH-1:0] j_minus;
  logic [FLOAT_WIDTH-1:0] delta_j;
  logic [CNT_WIDTH-1:0]   pair_count;
  logic                   handshake;
  logic                   drop;

  // Both operands are unsigned, so one guard bit holds the exact difference;
  // the top two bits disagreeing means the result left the signed range.
  function automatic logic [FLOAT_WIDTH-1:0] sat_sub(
    input logic [FLOAT_WIDTH-1:0] a,
    input logic [FLOAT_WIDTH-1:0] b
  );
    logic signed [FLOAT_WIDTH:0] diff;
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    if (!diff[FLOAT_WIDTH] && diff[FLOAT_WIDTH-1])
      return {1'b0, {(FLOAT_WIDTH-1){1'b1}}};
    else if (diff[FLOAT_WIDTH] && !diff[FLOAT_WIDTH-1])
      return {1'b1, {(FLOAT_WIDTH-1){1'b0}}};
    else
      return diff[FLOAT_WIDTH-1:0];
  endfunction

  assign handshake = delta_valid && bus.DELTA_READY;
  assign drop      = (state == PRESENT) && bus.REG_WRITE && !handshake && !bus.REG_RST;

  always_ff @(posedge ADC_CLK) begin
    if (!RST_N) begin
      state       <= WAIT_PLUS;
      pert_sel    <= 1'b0;
      delta_valid <= 1'b0;
      overrun     <= 1'b0;
      j_plus      <= '0;
      j_minus     <= '0;
      delta_j     <= '0;
      pair_count  <= '0;
    end else begin
      if (drop)
        overrun <= 1'b1;
      else if (bus.CLR_OVERRUN)
        overrun <= 1'b0;

      if (bus.REG_RST) begin
        state       <= WAIT_PLUS;
        pert_sel    <= 1'b0;
        delta_valid <= 1'b0;
      end else begin
        case (state)
          WAIT_PLUS: begin
            if (bus.REG_WRITE) begin
              j_plus   <= bus.DATA_IN;
              state    <= WAIT_MINUS;
              pert_sel <= 1'b1;
            end
          end
          WAIT_MINUS: begin
            if (bus.REG_WRITE) begin
              j_minus     <= bus.DATA_IN;
              delta_j     <= sat_sub(j_plus, bus.DATA_IN);
              state       <= PRESENT;
              pert_sel    <= 1'b0;
              delta_valid <= 1'b1;
            end
          end
          PRESENT: begin
            if (handshake) begin
              pair_count  <= pair_count + 1'b1;
              delta_valid <= 1'b0;
              // A strobe coinciding with the handshake starts the next pair.
              if (bus.REG_WRITE) begin
                j_plus   <= bus.DATA_IN;
                state    <= WAIT_MINUS;
                pert_sel <= 1'b1;
              end else begin
                state    <= WAIT_PLUS;
              end
            end
          end
          default: begin
            state       <= WAIT_PLUS;
            pert_sel    <= 1'b0;
            delta_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.PERT_SEL    = pert_sel;
  assign bus.DELTA_VALID = delta_valid;
  assign bus.OVERRUN     = overrun;
  assign bus.J_PLUS      = j_plus;
  assign bus.J_MINUS     = j_minus;
  assign bus.DELTA_J     = delta_j;
  assign bus.PAIR_COUNT  = pair_count;

endmodule

// File: tb/tb_spgd_metric_pair.sv
// Directed and randomized bench for spgd_metric_pair against a pair-tracking
// reference model; the counter is built 4 bits wide so wrap-around is reachable.
module tb_spgd_metric_pair;

  localparam int FW = 64;
  localparam int CW = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  spgd_metric_pair_if #(.FLOAT_WIDTH(FW), .CNT_WIDTH(CW)) bus ();

  spgd_metric_pair #(.FLOAT_WIDTH(FW), .INT_WIDTH(16), .CNT_WIDTH(CW)) dut (
    .ADC_CLK (clk),
    .RST_N   (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: "holding a J+" and "a dJ awaits acknowledge" flags.
  bit          m_have_plus;
  bit          m_pending;
  bit          m_overrun;
  logic [63:0] m_jp, m_jm, m_dj;
  logic [CW-1:0] m_cnt;

  function automatic logic [63:0] ref_delta(input logic [63:0] p, input logic [63:0] m);
    logic [63:0] mag;
    if (p >= m) begin
      mag = p - m;
      return (mag > 64'h7FFF_FFFF_FFFF_FFFF) ? 64'h7FFF_FFFF_FFFF_FFFF : mag;
    end else begin
      mag = m - p;
      return (mag > 64'h8000_0000_0000_0000) ? 64'h8000_0000_0000_0000 : (~mag + 64'd1);
    end
  endfunction

  task automatic model_step();
    bit drop;
    drop = 1'b0;
    if (!rst_n) begin
      m_have_plus = 0; m_pending = 0; m_overrun = 0;
      m_jp = '0; m_jm = '0; m_dj = '0; m_cnt = '0;
    end else begin
      if (bus.REG_RST) begin
        m_have_plus = 0;
        m_pending   = 0;
      end else begin
        if (m_pending && bus.DELTA_READY) begin
          m_cnt     = m_cnt + 1'b1;
          m_pending = 0;
        end
        if (bus.REG_WRITE) begin
          if (m_pending) drop = 1'b1;
          else if (!m_have_plus) begin
            m_jp = bus.DATA_IN; m_have_plus = 1;
          end else begin
            m_jm = bus.DATA_IN; m_dj = ref_delta(m_jp, bus.DATA_IN);
            m_have_plus = 0; m_pending = 1;
          end
        end
      end
      if (drop) m_overrun = 1'b1;
      else if (bus.CLR_OVERRUN) m_overrun = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pert_sel",    64'(bus.PERT_SEL),    64'(m_have_plus));
    chk("delta_valid", 64'(bus.DELTA_VALID), 64'(m_pending));
    chk("overrun",     64'(bus.OVERRUN),     64'(m_overrun));
    chk("j_plus",      bus.J_PLUS,           m_jp);
    chk("j_minus",     bus.J_MINUS,          m_jm);
    chk("delta_j",     bus.DELTA_J,          m_dj);
    chk("pair_count",  64'(bus.PAIR_COUNT),  64'(m_cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_pair(input logic [63:0] a, input logic [63:0] b);
    bus.REG_WRITE = 1'b1; bus.DATA_IN = a; tick();
    bus.DATA_IN = b; tick();
    bus.REG_WRITE = 1'b0; tick();
  endtask

  function automatic logic [63:0] rand_word();
    case ($urandom_range(0, 3))
      0:       return 64'h0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    n_checks = 0; n_fail = 0;
    m_have_plus = 0; m_pending = 0; m_overrun = 0;
    m_jp = '0; m_jm = '0; m_dj = '0; m_cnt = '0;
    rst_n = 1'b0;
    bus.DATA_IN = '0; bus.REG_WRITE = 1'b0; bus.REG_RST = 1'b0;
    bus.DELTA_READY = 1'b0; bus.CLR_OVERRUN = 1'b0;
    tick(); tick();
    chk("reset_count", 64'(bus.PAIR_COUNT), 64'd0);
    chk("reset_dj", bus.DELTA_J, 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic pair 3.0 - 1.25 with downstream ready
    bus.DELTA_READY = 1'b1;
    chk("basic_pert0", 64'(bus.PERT_SEL), 64'd0);
    bus.REG_WRITE = 1'b1; bus.DATA_IN = 64'h0003_0000_0000_0000; tick();
    chk("basic_pert1", 64'(bus.PERT_SEL), 64'd1);
    bus.DATA_IN = 64'h0001_4000_0000_0000; tick();
    bus.REG_WRITE = 1'b0;
    chk("basic_dj", bus.DELTA_J, 64'h0001_C000_0000_0000);
    chk("basic_valid", 64'(bus.DELTA_VALID), 64'd1);
    tick();
    chk("basic_valid_fall", 64'(bus.DELTA_VALID), 64'd0);
    chk("basic_count", 64'(bus.PAIR_COUNT), 64'd1);
    chk("basic_pert_end", 64'(bus.PERT_SEL), 64'd0);

    // Negative result and both saturation limits
    do_pair(64'h0001_0000_0000_0000, 64'h0003_0000_0000_0000);
    chk("neg_dj", bus.DELTA_J, 64'hFFFE_0000_0000_0000);
    do_pair(64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    chk("sat_pos", bus.DELTA_J, 64'h7FFF_FFFF_FFFF_FFFF);
    do_pair(64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sat_neg", bus.DELTA_J, 64'h8000_0000_0000_0000);

    // Backpressure, overrun, clear, and handshake with coincident strobe
    bus.DELTA_READY = 1'b0;
    bus.REG_WRITE = 1'b1; bus.DATA_IN = 64'h0003_0000_0000_0000; tick();
    bus.DATA_IN = 64'h0000_8000_0000_0000; tick();
    bus.REG_WRITE = 1'b0;
    repeat (10) tick();
    chk("bp_dj_stable", bus.DELTA_J, 64'h0002_8000_0000_0000);
    bus.REG_WRITE = 1'b1; bus.DATA_IN = 64'h0007_0000_0000_0000; tick();
    bus.REG_WRITE = 1'b0;
    chk("bp_overrun", 64'(bus.OVERRUN), 64'd1);
    chk("bp_still_valid", 64'(bus.DELTA_VALID), 64'd1);
    chk("bp_jplus_kept", bus.J_PLUS, 64'h0003_0000_0000_0000);
    bus.CLR_OVERRUN = 1'b1; tick();
    bus.CLR_OVERRUN = 1'b0;
    chk("clr_overrun", 64'(bus.OVERRUN), 64'd0);
    bus.DELTA_READY = 1'b1;
    bus.REG_WRITE = 1'b1; bus.DATA_IN = 64'h0002_0000_0000_0000; tick();
    bus.REG_WRITE = 1'b0;
    chk("hs_jplus", bus.J_PLUS, 64'h0002_0000_0000_0000);
    chk("hs_pert", 64'(bus.PERT_SEL), 64'd1);
    chk("hs_no_overrun", 64'(bus.OVERRUN), 64'd0);

    // REG_RST mid-pair beats a coincident strobe
    bus.REG_RST = 1'b1; tick();
    bus.REG_RST = 1'b0;
    bus.REG_WRITE = 1'b1; bus.DATA_IN = 64'h0005_0000_0000_0000; tick();
    bus.REG_RST = 1'b1; bus.DATA_IN = 64'h0001_0000_0000_0000; tick();
    bus.REG_RST = 1'b0; bus.REG_WRITE = 1'b0;
    chk("rr_pert", 64'(bus.PERT_SEL), 64'd0);
    chk("rr_jminus", bus.J_MINUS, 64'h0000_8000_0000_0000);
    chk("rr_overrun", 64'(bus.OVERRUN), 64'd0);
    tick();
    chk("rr_no_valid", 64'(bus.DELTA_VALID), 64'd0);

    // Counter wrap after 17 acknowledged pairs
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) do_pair(rand_word(), rand_word());
    chk("wrap_count", 64'(bus.PAIR_COUNT), 64'd1);

    // Reset while presenting with ready high
    bus.DELTA_READY = 1'b0;
    bus.REG_WRITE = 1'b1; bus.DATA_IN = 64'h0004_0000_0000_0000; tick();
    bus.DATA_IN = 64'h0001_0000_0000_0000; tick();
    bus.REG_WRITE = 1'b0; bus.DELTA_READY = 1'b1; rst_n = 1'b0; tick();
    chk("rst_present_count", 64'(bus.PAIR_COUNT), 64'd0);
    chk("rst_present_valid", 64'(bus.DELTA_VALID), 64'd0);
    chk("rst_present_jplus", bus.J_PLUS, 64'd0);
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      bus.REG_WRITE   = ($urandom_range(0, 1) == 1);
      bus.DELTA_READY = ($urandom_range(0, 2) != 0);
      bus.REG_RST     = ($urandom_range(0, 15) == 0);
      bus.CLR_OVERRUN = ($urandom_range(0, 15) == 0);
      rst_n           = ($urandom_range(0, 63) != 0);
      bus.DATA_IN     = rand_word();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
